// File: rtl/regfile_n.sv
// DEPTH x WIDTH general register file with one load/inc/dec port, a tristate bus read port,
// an always-driven ALU read port and a registered wrap pulse for inc/dec overflow.
module regfile_n #(
  parameter int                 WIDTH     = 8,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '1,
  localparam int                SELW      = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_nReset,
  input  logic [WIDTH-1:0]  i_d,
  input  logic [1:0]        i_op,
  input  logic [SELW-1:0]   i_wrSel,
  input  logic [SELW-1:0]   i_busSel,
  input  logic              i_nBusEn,
  output logic [WIDTH-1:0]  o_bus,
  input  logic [SELW-1:0]   i_aluSel,
  output logic [WIDTH-1:0]  o_alu,
  output logic              o_zero,
  output logic              o_wrap
);

  localparam int NSLOT = 1 << SELW;

  localparam logic [1:0] OpNone = 2'b00;
  localparam logic [1:0] OpLoad = 2'b01;
  localparam logic [1:0] OpInc  = 2'b10;
  localparam logic [1:0] OpDec  = 2'b11;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] rd_tab [NSLOT];
  logic             wrap_q;
  logic             wrap_d;

  // An out-of-range i_wrSel matches no register, so nothing changes and wrap_d stays 0.
  always_comb begin
    wrap_d = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (i_wrSel == SELW'(i)) begin
        case (i_op)
          OpLoad: regs_d[i] = i_d;
          OpInc: begin
            regs_d[i] = regs_q[i] + WIDTH'(1);
            wrap_d    = &regs_q[i];
          end
          OpDec: begin
            regs_d[i] = regs_q[i] - WIDTH'(1);
            wrap_d    = ~|regs_q[i];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      wrap_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wrap_q <= wrap_d;
    end
  end

  // Read table padded to a power of two; slots past DEPTH read as zero.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      rd_tab[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_tab[i] = regs_q[i];
    end
  end

  assign o_alu  = rd_tab[i_aluSel];
  assign o_zero = ~|o_alu;
  assign o_bus  = i_nBusEn ? {WIDTH{1'bz}} : rd_tab[i_busSel];
  assign o_wrap = wrap_q;

endmodule

// File: tb/tb_regfile_n.sv
// Directed bench for regfile_n: a DEPTH=4 and a DEPTH=3 instance driven from shared inputs.
module tb_regfile_n;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [7:0] d;
  logic [1:0] op;
  logic [1:0] wr_sel;
  logic [1:0] bus_sel;
  logic       n_bus_en;
  logic [1:0] alu_sel;

  wire  [7:0] bus4;
  wire  [7:0] bus3;
  logic [7:0] alu4, alu3;
  logic       zero4, zero3, wrap4, wrap3;

  // Bench keeper on bus4: only reads back its own value if the DUT has released the bus.
  logic       tb_drv;
  assign bus4 = tb_drv ? 8'hA5 : 8'hzz;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_n #(.WIDTH(8), .DEPTH(4)) dut4 (
    .i_clk(clk), .i_nReset(n_reset), .i_d(d), .i_op(op), .i_wrSel(wr_sel),
    .i_busSel(bus_sel), .i_nBusEn(n_bus_en), .o_bus(bus4), .i_aluSel(alu_sel),
    .o_alu(alu4), .o_zero(zero4), .o_wrap(wrap4)
  );

  regfile_n #(.WIDTH(8), .DEPTH(3)) dut3 (
    .i_clk(clk), .i_nReset(n_reset), .i_d(d), .i_op(op), .i_wrSel(wr_sel),
    .i_busSel(bus_sel), .i_nBusEn(n_bus_en), .o_bus(bus3), .i_aluSel(alu_sel),
    .o_alu(alu3), .o_zero(zero3), .o_wrap(wrap3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] sel, input logic [7:0] val);
    op = 2'b01; wr_sel = sel; d = val;
    step();
    op = 2'b00;
  endtask

  task automatic rd4(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    alu_sel = sel;
    #1;
    check(tag, {24'd0, alu4}, {24'd0, exp});
  endtask

  task automatic rd3(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    alu_sel = sel;
    #1;
    check(tag, {24'd0, alu3}, {24'd0, exp});
  endtask

  initial begin
    n_reset = 1'b0; d = '0; op = 2'b00; wr_sel = '0; bus_sel = '0;
    n_bus_en = 1'b1; alu_sel = '0; tb_drv = 1'b0;
    #3 n_reset = 1'b1;
    step();

    // Reset mid-cycle with a load pending; reg0 preloaded so the reset is visible.
    write(2'd0, 8'h11);
    rd4("preload_r0", 2'd0, 8'h11);
    op = 2'b01; wr_sel = 2'd0; d = 8'h33;
    #1 n_reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      rd4($sformatf("rst_r%0d", i), 2'(i), 8'hFF);
    end
    check("rst_wrap", {31'd0, wrap4}, 32'd0);
    step();
    op = 2'b00;
    n_reset = 1'b1;
    step();
    rd4("rst_load_lost", 2'd0, 8'hFF);

    // Load and tristate.
    write(2'd2, 8'h5A);
    write(2'd3, 8'hC3);
    rd4("load_r2", 2'd2, 8'h5A);
    check("load_zero", {31'd0, zero4}, 32'd0);
    bus_sel = 2'd3; n_bus_en = 1'b0;
    #1 check("bus_drive", {24'd0, bus4}, 32'hC3);
    n_bus_en = 1'b1; tb_drv = 1'b1;
    #1 check("bus_release", {24'd0, bus4}, 32'hA5);
    tb_drv = 1'b0;

    // Increment wrap on reg1 (0xFF after reset).
    op = 2'b10; wr_sel = 2'd1; alu_sel = 2'd1;
    step();
    rd4("inc_wrap_r1", 2'd1, 8'h00);
    check("inc_zero", {31'd0, zero4}, 32'd1);
    check("inc_wrap", {31'd0, wrap4}, 32'd1);
    step();
    op = 2'b00;
    rd4("inc2_r1", 2'd1, 8'h01);
    check("inc2_wrap", {31'd0, wrap4}, 32'd0);

    // Decrement sequence through zero.
    write(2'd0, 8'h01);
    op = 2'b11; wr_sel = 2'd0;
    step();
    rd4("dec1_r0", 2'd0, 8'h00);
    check("dec1_wrap", {31'd0, wrap4}, 32'd0);
    step();
    rd4("dec2_r0", 2'd0, 8'hFF);
    check("dec2_wrap", {31'd0, wrap4}, 32'd1);
    step();
    op = 2'b00;
    rd4("dec3_r0", 2'd0, 8'hFE);
    check("dec3_wrap", {31'd0, wrap4}, 32'd0);

    // Read-during-write: old value until the edge, new value after.
    write(2'd2, 8'h10);
    alu_sel = 2'd2; op = 2'b01; wr_sel = 2'd2; d = 8'h20;
    #1 check("rdw_before", {24'd0, alu4}, 32'h10);
    step();
    op = 2'b00;
    check("rdw_after", {24'd0, alu4}, 32'h20);
    rd4("rdw_r0", 2'd0, 8'hFE);
    rd4("rdw_r1", 2'd1, 8'h01);
    rd4("rdw_r3", 2'd3, 8'hC3);

    // Non-power-of-two depth: select 3 is out of range on dut3.
    n_reset = 1'b0;
    #2 n_reset = 1'b1;
    op = 2'b10; wr_sel = 2'd0;
    step();
    check("d3_wrap_set", {31'd0, wrap3}, 32'd1);
    wr_sel = 2'd3;
    step();
    op = 2'b00;
    check("d3_oor_inc_wrap", {31'd0, wrap3}, 32'd0);
    write(2'd3, 8'h77);
    rd3("d3_oor_read", 2'd3, 8'h00);
    check("d3_oor_zero", {31'd0, zero3}, 32'd1);
    rd3("d3_r0", 2'd0, 8'h00);
    rd3("d3_r1", 2'd1, 8'hFF);
    rd3("d3_r2", 2'd2, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_n.md
Name: regfile_n

Overview:
- Parametrised successor of the two-register set: DEPTH general registers of WIDTH bits.
- One write/modify port and two independent read ports:
  - bus port: tristated onto the shared data bus;
  - ALU port: always driven, feeds the ALU operand mux.
- Adds in-place increment/decrement so a register can act as a pointer or counter without an ALU pass, plus a registered wrap flag.
- Sits in the datapath between the data bus, the ALU operand input and the control decoder.

Parameters:
- WIDTH, 8, register and data width in bits (>=2).
- DEPTH, 4, number of registers (>=2, need not be a power of two).
- RESET_VAL, all ones of WIDTH, value loaded into every register on reset.
- SELW, clog2(DEPTH), derived localparam; width of all select inputs.

Ports:
- i_clk, input, 1, rising-edge clock.
- i_nReset, input, 1, asynchronous active-low reset.
- i_d, input, WIDTH, write data.
- i_op, input, 2, modify operation: 00 none, 01 load i_d, 10 increment, 11 decrement.
- i_wrSel, input, SELW, target register of i_op.
- i_busSel, input, SELW, register driven to the bus.
- i_nBusEn, input, 1, active-low bus drive enable.
- o_bus, output (tristate), WIDTH, bus data; high-Z when i_nBusEn=1.
- i_aluSel, input, SELW, register presented to the ALU.
- o_alu, output, WIDTH, ALU operand.
- o_zero, output, 1, 1 when o_alu == 0.
- o_wrap, output, 1, registered pulse: the last inc/dec wrapped.

Behaviour:
- Reset:
  - Asserting i_nReset=0 immediately (no clock needed) forces all registers to RESET_VAL and o_wrap to 0.
  - Deassertion is synchronised by the surrounding design; the block simply samples normally from the first rising edge with i_nReset=1.
  - Reset overrides any i_op in progress; that edge performs no write.
- Read ports are combinational:
  - o_alu = reg[i_aluSel];
  - o_bus = reg[i_busSel] when i_nBusEn=0, else all Z, with the same semantics as the transmitter cell;
  - o_zero follows o_alu combinationally.
- Out-of-range select (index >= DEPTH):
  - reads return 0;
  - i_op on an out-of-range i_wrSel is ignored, and o_wrap is cleared on that edge.
- Modify (on rising i_clk, i_nReset=1, i_wrSel valid):
  - 01: reg <= i_d.
  - 10: reg <= reg+1, modulo 2^WIDTH.
  - 11: reg <= reg-1, modulo 2^WIDTH.
  - 00: no change.
- Only one register is modified per cycle. All other registers hold.
- o_wrap:
  - set to 1 for exactly one cycle after an increment from all-ones to 0, or a decrement from 0 to all-ones;
  - cleared on every other edge, including load and none.
  - Back-to-back wraps keep it high on consecutive cycles.
- Read-during-write: reads return the pre-edge value until the edge, then the new value. There is no bypass; the write is visible in the cycle after the edge.
- Latency:
  - load/inc/dec: 1 cycle to visibility on both read ports;
  - o_wrap: 1 cycle after the causing edge.
- Bus and ALU selects may equal each other and/or i_wrSel simultaneously; there are no conflicts.
- No X propagation: every register has a defined value from reset onward.

Test Plan:
- Reset: WIDTH=8, DEPTH=4. Pulse i_nReset=0 mid-cycle with i_op=01 pending.
  -> All regs read 0xFF immediately, before any clock edge.
  -> o_wrap=0. The pending load is lost.
- Load and tristate: load reg2=0x5A, reg3=0xC3.
  -> i_aluSel=2 gives o_alu=0x5A, o_zero=0.
  -> i_busSel=3, i_nBusEn=0 gives o_bus=0xC3.
  -> i_nBusEn=1 gives o_bus=Z.
- Increment wrap: reg1 is 0xFF after reset; apply i_op=10.
  -> Next cycle reg1=0x00, o_zero=1 with i_aluSel=1, o_wrap=1.
  -> A second inc gives reg1=0x01 and o_wrap back to 0.
- Decrement wrap and back-to-back: reg0=0x01; apply dec, dec, dec on consecutive cycles.
  -> reg0 sequence 0x00, 0xFF, 0xFE.
  -> o_wrap sequence 0, 1, 0.
- Read-during-write: reg2=0x10, i_aluSel=2, i_op=01, i_d=0x20.
  -> o_alu=0x10 before the edge and 0x20 after it.
  -> Other registers unchanged.
- Non-power-of-two: DEPTH=3 (SELW=2). i_wrSel=3 load 0x77, then i_aluSel=3.
  -> o_alu=0; regs 0..2 unchanged.
  -> inc on sel 3 leaves o_wrap=0.
